// File: rtl/dec_pkg.sv
// Shared definitions for the sequential latent decoder: fixed-point format,
// output-neuron weight/bias tables, saturation helper and FSM state type.
package dec_pkg;

  localparam int N_OUT = 9;
  localparam int DW    = 20;
  localparam int FRAC  = 12;
  // Wide enough that two shifted 40-bit products plus a bias never wrap
  // before saturation (each shifted product fits in 28 bits).
  localparam int SUM_W = 30;

  localparam logic signed [DW-1:0] THRESH   = 20'sh00800;
  localparam logic [3:0]           LAST_IDX = 4'd8;

  localparam logic signed [SUM_W-1:0] SAT_HI = 30'sh0007FFFF;
  localparam logic signed [SUM_W-1:0] SAT_LO = 30'sh3FF80000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Same output-neuron set as the encoder side.
  localparam logic signed [DW-1:0] WN1 [0:N_OUT-1] = '{
    20'sh0A1C4, 20'sh2D0AB, 20'sh09DCB, 20'sh2CAC8, 20'shD656D,
    20'sh2D5EF, 20'sh0A82D, 20'sh2CE81, 20'sh096AE
  };
  localparam logic signed [DW-1:0] WN2 [0:N_OUT-1] = '{
    20'sh165EE, 20'shF1FBB, 20'sh15212, 20'shF12E7, 20'sh15EA0,
    20'shF2E17, 20'sh171F5, 20'shF197E, 20'sh14663
  };
  localparam logic signed [DW-1:0] BN [0:N_OUT-1] = '{
    20'sh21DD0, 20'shFDA10, 20'sh222D7, 20'shFDCBE, 20'sh00CBD,
    20'shFD764, 20'sh21ADF, 20'shFDB31, 20'sh225A6
  };

  // Clamp a wide signed sum into the signed 20-bit range.
  function automatic logic signed [DW-1:0] sat20(input logic signed [SUM_W-1:0] x);
    logic signed [DW-1:0] r;
    if (x > SAT_HI) begin
      r = 20'sh7FFFF;
    end else if (x < SAT_LO) begin
      r = 20'sh80000;
    end else begin
      r = x[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/latent_decoder_seq_if.sv
// Handshake and data bus of the latent decoder: latent input, probability
// stream and reconstructed-pixel output.
interface latent_decoder_seq_if;
  import dec_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] h1;
  logic signed [DW-1:0] h2;
  logic                 prob_valid;
  logic [3:0]           prob_idx;
  logic signed [DW-1:0] prob_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_OUT-1:0]     pixel_out;

  modport master (
    output in_valid, h1, h2, out_ready,
    input  in_ready, prob_valid, prob_idx, prob_data, out_valid, pixel_out
  );

  modport slave (
    input  in_valid, h1, h2, out_ready,
    output in_ready, prob_valid, prob_idx, prob_data, out_valid, pixel_out
  );

endinterface

// File: rtl/dec_mac.sv
// Combinational two-term multiply-accumulate plus bias for one output
// neuron, with arithmetic (floor) rescaling and 20-bit saturation.
module dec_mac
  import dec_pkg::*;
(
  input  logic signed [DW-1:0] h1,
  input  logic signed [DW-1:0] h2,
  input  logic signed [DW-1:0] w1,
  input  logic signed [DW-1:0] w2,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] n
);

  logic signed [2*DW-1:0]  p1_s;
  logic signed [2*DW-1:0]  p2_s;
  logic signed [SUM_W-1:0] sum_s;

  // Full-precision products, rescale to Q12, accumulate wide, then clamp.
  always_comb begin
    p1_s  = h1 * w1;
    p2_s  = h2 * w2;
    sum_s = SUM_W'(p1_s >>> FRAC) + SUM_W'(p2_s >>> FRAC) + SUM_W'(b);
    n     = sat20(sum_s);
  end

endmodule

// File: rtl/sigmoid.sv
// Piecewise-linear sigmoid in Q7.12: power-of-two slopes on |x| segments
// [0,1), [1,2.375), [2.375,5), saturating at 1.0; negative inputs use
// sigmoid(-x) = 1 - sigmoid(x).
module sigmoid (
  input  logic signed [19:0] x,
  output logic signed [19:0] y
);

  logic [20:0] ax_s;
  logic [20:0] f_s;

  // Magnitude, segment selection and symmetric reflection.
  always_comb begin
    if (x[19]) begin
      ax_s = 21'd0 - {x[19], x};
    end else begin
      ax_s = {1'b0, x};
    end

    if (ax_s >= 21'd20480) begin
      f_s = 21'd4096;
    end else if (ax_s >= 21'd9728) begin
      f_s = (ax_s >> 5) + 21'd3456;
    end else if (ax_s >= 21'd4096) begin
      f_s = (ax_s >> 3) + 21'd2560;
    end else begin
      f_s = (ax_s >> 2) + 21'd2048;
    end

    if (x[19]) begin
      y = 20'(21'd4096 - f_s);
    end else begin
      y = 20'(f_s);
    end
  end

endmodule

// File: rtl/latent_decoder_seq.sv
// Sequential decoder: accepts a latent pair, evaluates the 9 output neurons
// one per cycle on a shared MAC + sigmoid, streams each probability, then
// holds the thresholded pixel until the downstream takes it.
module latent_decoder_seq
  import dec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  latent_decoder_seq_if.slave bus
);

  state_e               state_r;
  state_e               next_state_s;
  logic [3:0]           idx_r;
  logic signed [DW-1:0] h1_r;
  logic signed [DW-1:0] h2_r;
  logic [N_OUT-1:0]     pixel_r;
  logic                 in_ready_r;
  logic                 prob_valid_r;
  logic [3:0]           prob_idx_r;
  logic signed [DW-1:0] prob_data_r;
  logic                 out_valid_r;

  logic                 accept_s;
  logic                 release_s;
  logic                 last_s;
  logic signed [DW-1:0] w1_s;
  logic signed [DW-1:0] w2_s;
  logic signed [DW-1:0] b_s;
  logic signed [DW-1:0] n_s;
  logic signed [DW-1:0] s_s;

  assign accept_s  = (state_r == IDLE) && bus.in_valid && in_ready_r;
  assign release_s = (state_r == DONE) && out_valid_r && bus.out_ready;
  assign last_s    = (idx_r == LAST_IDX);

  assign w1_s = WN1[idx_r];
  assign w2_s = WN2[idx_r];
  assign b_s  = BN[idx_r];

  dec_mac u_mac (
    .h1 (h1_r),
    .h2 (h2_r),
    .w1 (w1_s),
    .w2 (w2_s),
    .b  (b_s),
    .n  (n_s)
  );

  sigmoid u_sigmoid (
    .x (n_s),
    .y (s_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode: accept -> 9 neuron cycles -> wait for pixel handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (release_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath: latent latch, neuron index, pixel build-up and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= 4'd0;
      h1_r         <= 20'sd0;
      h2_r         <= 20'sd0;
      pixel_r      <= 9'd0;
      in_ready_r   <= 1'b0;
      prob_valid_r <= 1'b0;
      prob_idx_r   <= 4'd0;
      prob_data_r  <= 20'sd0;
      out_valid_r  <= 1'b0;
    end else begin
      // Ready is registered, so it only reopens the cycle after a release.
      in_ready_r   <= (next_state_s == IDLE);
      prob_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            h1_r    <= bus.h1;
            h2_r    <= bus.h2;
            idx_r   <= 4'd0;
            pixel_r <= 9'd0;
          end
        end
        CALC: begin
          prob_valid_r   <= 1'b1;
          prob_idx_r     <= idx_r;
          prob_data_r    <= s_s;
          pixel_r[idx_r] <= (s_s >= THRESH);
          if (last_s) begin
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        DONE: begin
          if (release_s) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.prob_valid = prob_valid_r;
  assign bus.prob_idx   = prob_idx_r;
  assign bus.prob_data  = prob_data_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.pixel_out  = pixel_r;

endmodule

// File: tb/tb_latent_decoder_seq.sv
// Self-checking bench for latent_decoder_seq: an arithmetic model of the
// neuron/sigmoid/threshold rules feeds expectation queues that a single
// negedge compare process checks, plus directed timing and literal checks.
module tb_latent_decoder_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   prob_cnt = 0;
  int   out_cnt  = 0;

  int exp_idx_q [$];
  int exp_dat_q [$];
  int exp_pix_q [$];
  int cmp_idx;
  int cmp_dat;

  logic [19:0] got [0:15];

  int w1_raw [0:8] = '{32'sh0A1C4, 32'sh2D0AB, 32'sh09DCB, 32'sh2CAC8, 32'shD656D,
                       32'sh2D5EF, 32'sh0A82D, 32'sh2CE81, 32'sh096AE};
  int w2_raw [0:8] = '{32'sh165EE, 32'shF1FBB, 32'sh15212, 32'shF12E7, 32'sh15EA0,
                       32'shF2E17, 32'sh171F5, 32'shF197E, 32'sh14663};
  int bn_raw [0:8] = '{32'sh21DD0, 32'shFDA10, 32'sh222D7, 32'shFDCBE, 32'sh00CBD,
                       32'shFD764, 32'sh21ADF, 32'shFDB31, 32'sh225A6};

  latent_decoder_seq_if bus ();

  latent_decoder_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Standalone MAC + sigmoid for exact-boundary checks.
  logic signed [19:0] m_h1, m_h2, m_w1, m_w2, m_b, m_n, sg_y;

  dec_mac u_mac (
    .h1 (m_h1), .h2 (m_h2), .w1 (m_w1), .w2 (m_w2), .b (m_b), .n (m_n)
  );

  sigmoid u_sig (
    .x (m_n),
    .y (sg_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic int sx20(input int v);
    return (v >= 32'sd524288) ? v - 32'sd1048576 : v;
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if (((a % d) != 64'sd0) && ((a < 64'sd0) != (d < 64'sd0))) q = q - 64'sd1;
    return q;
  endfunction

  function automatic int model_neuron(input int a, input int b, input int k);
    longint s;
    s = floor_div(longint'(a) * longint'(sx20(w1_raw[k])), 64'sd4096)
      + floor_div(longint'(b) * longint'(sx20(w2_raw[k])), 64'sd4096)
      + longint'(sx20(bn_raw[k]));
    if (s > 64'sd524287) s = 64'sd524287;
    if (s < -64'sd524288) s = -64'sd524288;
    return int'(s);
  endfunction

  function automatic int model_sig(input int x);
    int ax;
    int f;
    ax = (x < 32'sd0) ? -x : x;
    if (ax >= 32'sd20480)     f = 32'sd4096;
    else if (ax >= 32'sd9728) f = 32'sd3456 + ax / 32'sd32;
    else if (ax >= 32'sd4096) f = 32'sd2560 + ax / 32'sd8;
    else                      f = 32'sd2048 + ax / 32'sd4;
    return (x < 32'sd0) ? 32'sd4096 - f : f;
  endfunction

  function automatic int model_pixel(input int a, input int b);
    int p;
    p = 0;
    for (int k = 0; k < 9; k++)
      if (model_sig(model_neuron(a, b, k)) >= 32'sd2048) p = p | (1 << k);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (bus.prob_valid) begin
      prob_cnt++;
      checks++;
      if (exp_idx_q.size() == 0) begin
        failures++;
        $display("FAIL prob_unexpected actual idx=%0d required no strobe", bus.prob_idx);
      end else begin
        cmp_idx = exp_idx_q.pop_front();
        cmp_dat = exp_dat_q.pop_front();
        chk("prob_idx", {28'd0, bus.prob_idx}, 32'(cmp_idx));
        chk("prob_data", {12'd0, bus.prob_data}, 32'(cmp_dat) & 32'h000FFFFF);
      end
    end
    if (bus.out_valid) begin
      checks++;
      if (exp_pix_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected actual pixel=%h required no out_valid", bus.pixel_out);
      end else begin
        chk("pixel_out", {23'd0, bus.pixel_out}, 32'(exp_pix_q[0]));
        if (bus.out_ready) begin
          void'(exp_pix_q.pop_front());
          out_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int a, input int b, output int t);
    bus.h1 = 20'(a);
    bus.h2 = 20'(b);
    bus.in_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        t = cyc;
        for (int k = 0; k < 9; k++) begin
          exp_idx_q.push_back(k);
          exp_dat_q.push_back(model_sig(model_neuron(a, b, k)));
        end
        exp_pix_q.push_back(model_pixel(a, b));
      end
    end
    bus.in_valid = 1'b0;
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no accept required=accept within 40 cycles");
    end
  endtask

  task automatic collect(input string name);
    int ns;
    int lat;
    ns  = 0;
    lat = -1;
    for (int i = 0; i < 16; i++) got[i] = 20'd0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.prob_valid) begin
        got[bus.prob_idx] = bus.prob_data;
        ns++;
      end
      if (bus.out_valid) lat = i;
    end
    chk({name, "_strobes"}, 32'(ns), 32'd9);
    chk({name, "_latency"}, 32'(lat), 32'd9);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"},   {31'd0, bus.in_ready},   32'd0);
    chk({name, "_prob_valid"}, {31'd0, bus.prob_valid}, 32'd0);
    chk({name, "_prob_idx"},   {28'd0, bus.prob_idx},   32'd0);
    chk({name, "_prob_data"},  {12'd0, bus.prob_data},  32'd0);
    chk({name, "_out_valid"},  {31'd0, bus.out_valid},  32'd0);
    chk({name, "_pixel"},      {23'd0, bus.pixel_out},  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t1;
    int t2;
    int pc0;
    int oc0;
    int ep;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.h1 = 20'sd0;
    bus.h2 = 20'sd0;
    m_h1 = 20'sd0; m_h2 = 20'sd0; m_w1 = 20'sd0; m_w2 = 20'sd0; m_b = 20'sd0;

    // Model pins (hand-computed).
    chk("model_sig_b4",   32'(model_sig(32'sd3261)), 32'd2863);
    chk("model_sig_b1",   32'(model_sig(-32'sd9712)), 32'd322);
    chk("model_sig_max",  32'(model_sig(32'sd524287)), 32'd4096);
    chk("model_sig_min",  32'(model_sig(-32'sd524288)), 32'd0);
    chk("model_n1_sat",   32'(model_neuron(32'sd524287, 32'sd0, 1)), 32'h0007FFFF);
    chk("model_n4_sat",   32'(model_neuron(32'sd524287, 32'sd0, 4)), 32'hFFF80000);
    chk("model_n4_edge",  32'(model_neuron(32'sd82, 32'sd7, 4)), 32'hFFFFFFFD);
    chk("model_pix_zero", 32'(model_pixel(32'sd0, 32'sd0)), 32'h00000155);

    // Standalone MAC / sigmoid boundary checks.
    #1;
    chk("mac_zero_n", {12'd0, m_n}, 32'h00000000);
    chk("sig_zero_thresh", {12'd0, sg_y}, 32'h00000800);
    m_h1 = 20'sh01000; m_w1 = 20'sh02000; m_h2 = 20'shFF000; m_w2 = 20'sh00800; m_b = 20'sh00100;
    #1;
    chk("mac_mix_n", {12'd0, m_n}, 32'h00001900);
    chk("sig_mix", {12'd0, sg_y}, 32'h00000D20);
    m_h1 = 20'shFFFFF; m_w1 = 20'sh00001; m_h2 = 20'sd0; m_w2 = 20'sd0; m_b = 20'shFFFFE;
    #1;
    chk("mac_floor_n", {12'd0, m_n}, 32'h000FFFFD);
    chk("sig_neg_thresh", {12'd0, sg_y}, 32'h00000800);
    m_h1 = 20'sh80000; m_w1 = 20'sh7FFFF; m_b = 20'sd0;
    #1;
    chk("mac_sat_lo", {12'd0, m_n}, 32'h00080000);
    chk("sig_sat_lo", {12'd0, sg_y}, 32'h00000000);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Latent zero.
    send(0, 0, t1);
    collect("zero");
    chk("zero_pixel", {23'd0, bus.pixel_out}, 32'h00000155);
    chk("zero_p0", {12'd0, got[0]}, 32'h00001000);
    chk("zero_p1", {12'd0, got[1]}, 32'h00000142);
    chk("zero_p4", {12'd0, got[4]}, 32'h00000B2F);
    chk("zero_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("zero_prob_after", {31'd0, bus.prob_valid}, 32'd0);
    chk("zero_out_hold", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("zero_out_release", {31'd0, bus.out_valid}, 32'd0);
    chk("zero_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;

    // Saturation.
    send(524287, 0, t1);
    collect("sat");
    chk("sat_p1", {12'd0, got[1]}, 32'h00001000);
    chk("sat_p4", {12'd0, got[4]}, 32'h00000000);
    chk("sat_bit4", {31'd0, bus.pixel_out[4]}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("sat_out_release", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: hold 20 cycles with in_valid noise.
    send(4096, -2048, t1);
    collect("bp");
    ep = model_pixel(4096, -2048);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.h1 = 20'(i * 1234);
      bus.h2 = 20'(-i * 777);
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_pixel_stable", {23'd0, bus.pixel_out}, 32'(ep));
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_prob_quiet", {31'd0, bus.prob_valid}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back with out_ready tied high.
    pc0 = prob_cnt;
    oc0 = out_cnt;
    send(4096, 4096, t1);
    send(-8192, 2048, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd11);
    for (int i = 0; i < 30 && (out_cnt - oc0) < 2; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("b2b_strobes", 32'(prob_cnt - pc0), 32'd18);
    chk("b2b_pixels", 32'(out_cnt - oc0), 32'd2);
    chk("b2b_idle_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the cycle after E4.
    send(4096, 0, t1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_idx_q.delete();
    exp_dat_q.delete();
    exp_pix_q.delete();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_out", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_no_prob", {31'd0, bus.prob_valid}, 32'd0);
    end

    // Threshold boundary through the DUT: neuron 4 lands on n = -3, s = 0.5.
    send(82, 7, t1);
    collect("thr");
    chk("thr_p4", {12'd0, got[4]}, 32'h00000800);
    chk("thr_bit4", {31'd0, bus.pixel_out[4]}, 32'd1);
    @(posedge clk);
    #1;
    chk("thr_release", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("queues_drained", 32'(exp_idx_q.size() + exp_pix_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
